lz_normalizer_32: RTL

- Pipelined left-normalizer for the FP32 datapath shifter group. It is the left-direction counterpart of the right-shift alignment path.
- Takes a 32-bit unnormalized significand/result word, counts leading zeros, and shifts the word left until bit 31 is set.
- Returns the normalized word and the shift amount, which the exponent-adjust stage consumes.
- Two-stage pipeline with valid/ready handshakes on both sides; sits between the FP adder's add/sub stage and the rounding stage.

---
 rtl/lz_normalizer_32.sv | 151 +++++++++++++++
 1 files changed

// File: rtl/lz_normalizer_32.sv
// -----------------------------------------------------------------------------
// lz_normalizer_32
//
// Two-stage pipelined left-normalizer for the FP32 datapath. A 32-bit
// unnormalized word is shifted left until bit 31 is set; the shift amount
// (leading-zero count) is returned for the exponent-adjust stage.
//
//   S1 : registers the input word and its leading-zero count.
//   S2 : registers norm = data << lzc, the count, and an all-zero flag.
//        All out_* data ports come straight from S2 flops.
//
// Ports
//   clk_i        rising-edge clock
//   rst_i        synchronous, active-high reset
//   in_valid_i   input word valid
//   in_ready_o   block can accept an input this cycle
//   in_data_i    word to normalize
//   out_valid_o  result valid
//   out_ready_i  downstream accepts the result
//   out_norm_o   normalized word
//   out_lzc_o    leading-zero count, 0..WIDTH
//   out_zero_o   input word was all zeros
// -----------------------------------------------------------------------------
module lz_normalizer_32 #(
  parameter int WIDTH = 32,
  parameter int LZW   = 6
) (
  input  logic             clk_i,
  input  logic             rst_i,
  input  logic             in_valid_i,
  output logic             in_ready_o,
  input  logic [WIDTH-1:0] in_data_i,
  output logic             out_valid_o,
  input  logic             out_ready_i,
  output logic [WIDTH-1:0] out_norm_o,
  output logic [LZW-1:0]   out_lzc_o,
  output logic             out_zero_o
);

  // Priority scan from the MSB; an all-zero word yields WIDTH.
  function automatic logic [LZW-1:0] count_lz(input logic [WIDTH-1:0] w);
    logic [LZW-1:0] cnt;
    logic           found;
    cnt   = LZW'(WIDTH);
    found = 1'b0;
    for (int i = WIDTH - 1; i >= 0; i--) begin
      if (!found && w[i]) begin
        cnt   = LZW'(WIDTH - 1 - i);
        found = 1'b1;
      end else begin
        cnt   = cnt;
        found = found;
      end
    end
    return cnt;
  endfunction

  // Stage registers
  logic             s1_valid_q, s1_valid_d;
  logic [WIDTH-1:0] s1_data_q,  s1_data_d;
  logic [LZW-1:0]   s1_lzc_q,   s1_lzc_d;
  logic             s2_valid_q, s2_valid_d;
  logic [WIDTH-1:0] s2_norm_q,  s2_norm_d;
  logic [LZW-1:0]   s2_lzc_q,   s2_lzc_d;
  logic             s2_zero_q,  s2_zero_d;

  // Handshake terms
  logic s2_free_s;
  logic s2_load_s;
  logic in_xfer_s;

  // Handshake decode: S2 can take a word when empty or draining this cycle.
  // in_ready_o intentionally follows out_ready_i combinationally so a full
  // pipe can still accept a word in the same cycle it delivers one.
  always_comb begin
    s2_free_s  = !s2_valid_q || out_ready_i;
    s2_load_s  = s1_valid_q && s2_free_s;
    in_ready_o = !s1_valid_q || s2_free_s;
    in_xfer_s  = in_valid_i && in_ready_o;
  end

  // Next-state for both stages; data only moves on a real transfer so idle
  // input bus values never enter the pipe.
  always_comb begin
    s1_valid_d = s1_valid_q;
    s1_data_d  = s1_data_q;
    s1_lzc_d   = s1_lzc_q;
    s2_valid_d = s2_valid_q;
    s2_norm_d  = s2_norm_q;
    s2_lzc_d   = s2_lzc_q;
    s2_zero_d  = s2_zero_q;

    if (in_ready_o) begin
      s1_valid_d = in_valid_i;
    end else begin
      s1_valid_d = s1_valid_q;
    end

    if (in_xfer_s) begin
      s1_data_d = in_data_i;
      s1_lzc_d  = count_lz(in_data_i);
    end else begin
      s1_data_d = s1_data_q;
      s1_lzc_d  = s1_lzc_q;
    end

    if (s2_free_s) begin
      s2_valid_d = s1_valid_q;
    end else begin
      s2_valid_d = s2_valid_q;
    end

    if (s2_load_s) begin
      // A shift by WIDTH (all-zero word) yields zero, as required.
      s2_norm_d = s1_data_q << s1_lzc_q;
      s2_lzc_d  = s1_lzc_q;
      s2_zero_d = (s1_lzc_q == LZW'(WIDTH));
    end else begin
      s2_norm_d = s2_norm_q;
      s2_lzc_d  = s2_lzc_q;
      s2_zero_d = s2_zero_q;
    end
  end

  // Pipeline state register with synchronous reset that overrides any handshake.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      s1_valid_q <= 1'b0;
      s1_data_q  <= '0;
      s1_lzc_q   <= '0;
      s2_valid_q <= 1'b0;
      s2_norm_q  <= '0;
      s2_lzc_q   <= '0;
      s2_zero_q  <= 1'b0;
    end else begin
      s1_valid_q <= s1_valid_d;
      s1_data_q  <= s1_data_d;
      s1_lzc_q   <= s1_lzc_d;
      s2_valid_q <= s2_valid_d;
      s2_norm_q  <= s2_norm_d;
      s2_lzc_q   <= s2_lzc_d;
      s2_zero_q  <= s2_zero_d;
    end
  end

  assign out_valid_o = s2_valid_q;
  assign out_norm_o  = s2_norm_q;
  assign out_lzc_o   = s2_lzc_q;
  assign out_zero_o  = s2_zero_q;

endmodule
